// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch control stage.
package stopwatch_pkg;

  localparam int unsigned DefaultClkHz          = 10_000_000;
  localparam int unsigned DefaultDebounceCycles = 200_000;
  localparam int unsigned DefaultCntW           = 24;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StRun,
    StPause
  } state_e;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and seconds-counter control outputs of the stopwatch control stage.
interface stopwatch_ctrl_if
  import stopwatch_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
);

  logic             btn_start_n;
  logic             btn_clr_n;
  logic             start_stop_reg;
  logic [CNT_W-1:0] count;
  logic             count_enable;
  logic             clear_n;

  modport master (
    input  btn_start_n,
    input  btn_clr_n,
    output start_stop_reg,
    output count,
    output count_enable,
    output clear_n
  );

  modport slave (
    output btn_start_n,
    output btn_clr_n,
    input  start_stop_reg,
    input  count,
    input  count_enable,
    input  clear_n
  );

endinterface

// File: rtl/btn_debounce.sv
// Synchronises and debounces one active-low push-button; pulses press for one cycle
// on each accepted release-to-pressed transition.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_dly_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter restarts on every agreeing sample and on acceptance, so it tops out at
  // DEBOUNCE_CYCLES-1 and can never wrap.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_n;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_dly_q & ~level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/pause FSM and one-second timebase driving the seconds BCD counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = DefaultClkHz,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned CNT_W           = DefaultCntW
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] Reload = CNT_W'(CLK_HZ - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             start_press, clr_press;
  logic             clear_n, count_enable, start_stop_reg;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_db (
    .clk  (clk),
    .reset(reset),
    .btn_n(bus.btn_start_n),
    .press(start_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr_db (
    .clk  (clk),
    .reset(reset),
    .btn_n(bus.btn_clr_n),
    .press(clr_press)
  );

  // Clear has priority over start; presses during the clear cycle are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: state_d = StIdle;
      StIdle: begin
        if (clr_press)        state_d = StClear;
        else if (start_press) state_d = StRun;
      end
      StRun: begin
        if (clr_press)        state_d = StClear;
        else if (start_press) state_d = StPause;
      end
      StPause: begin
        if (clr_press)        state_d = StClear;
        else if (start_press) state_d = StRun;
      end
      default: state_d = StClear;
    endcase
  end

  // Reloading on entry to clear keeps count nonzero while clear_n is low.
  always_comb begin
    count_d = count_q;
    unique case (state_q)
      StRun:   count_d = (count_q == '0) ? Reload : count_q - 1'b1;
      StPause: count_d = count_q;
      default: count_d = Reload;
    endcase
    if (state_d == StClear) count_d = Reload;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StClear;
      count_q <= Reload;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    clear_n        = 1'b1;
    count_enable   = 1'b0;
    start_stop_reg = 1'b0;
    unique case (state_q)
      StClear: begin
        clear_n      = 1'b0;
        count_enable = 1'b1;
      end
      StRun: begin
        count_enable   = 1'b1;
        start_stop_reg = 1'b1;
      end
      StIdle, StPause: ;
      default: ;
    endcase
  end

  assign bus.clear_n        = clear_n;
  assign bus.count_enable   = count_enable;
  assign bus.start_stop_reg = start_stop_reg;
  assign bus.count          = count_q;

endmodule
